// File: rtl/bbox_tracker.sv
// Per-frame bounding box of mask rows holding a white run of at least MIN_RUN pixels.
// Define BBOX_MARGIN_EN to grow the latched box by MARGIN (clamped); this adds one cycle of latency.
module bbox_tracker #(
    parameter int H_ACT    = 640,
    parameter int V_ACT    = 480,
    parameter int X_START  = 144,
    parameter int Y_START  = 35,
    parameter int THRESH   = 512,
    parameter int MIN_RUN  = 8,
    parameter int MIN_ROWS = 4,
    parameter int MARGIN   = 4
) (
    input  logic        iCLK,
    input  logic        iRST_N,
    input  logic [12:0] iH_Cont,
    input  logic [12:0] iV_Cont,
    input  logic [9:0]  iMask,
    output logic [12:0] oX1,
    output logic [12:0] oX2,
    output logic [12:0] oY1,
    output logic [12:0] oY2,
    output logic        oValid,
    output logic        oDone
);
    localparam int RUN_W = $clog2(MIN_RUN + 1);
    localparam int ROW_W = $clog2(MIN_ROWS + 1);
`ifdef BBOX_MARGIN_EN
    localparam int MARG_EFF = MARGIN;
`else
    localparam int MARG_EFF = 0 * MARGIN;
`endif
    localparam logic [12:0]      XS      = 13'(X_START);
    localparam logic [12:0]      XE      = 13'(X_START + H_ACT);
    localparam logic [12:0]      YS      = 13'(Y_START);
    localparam logic [12:0]      YE      = 13'(Y_START + V_ACT);
    localparam logic [12:0]      MARG    = 13'(MARG_EFF);
    localparam logic [12:0]      WHITE   = 13'(THRESH);
    localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(MIN_RUN);
    localparam logic [ROW_W-1:0] ROW_MAX = ROW_W'(MIN_ROWS);

    typedef enum logic [1:0] {IDLE, ACCUM, LATCH} stateT;
    stateT state, stateNext;

    logic [12:0]      minX, maxX, minY, maxY, runStart;
    logic [RUN_W-1:0] run, runPost;
    logic [ROW_W-1:0] rowCnt;
    logic             rowq;

    logic hAct, vAct, white, fs, re, fe, latchNow;
    logic [12:0] startEff, x1Exp, x2Exp, y1Exp, y2Exp;

    assign hAct  = (iH_Cont >= XS) && (iH_Cont < XE);
    assign vAct  = (iV_Cont >= YS) && (iV_Cont < YE);
    assign white = hAct && vAct && ({3'b000, iMask} >= WHITE);
    assign fs    = (iV_Cont == YS) && (iH_Cont == XS - 13'd1);
    assign re    = (iH_Cont == XE) && vAct;
    assign fe    = (iV_Cont == YE) && (iH_Cont == XS - 13'd1);

    assign runPost  = (run == RUN_MAX) ? RUN_MAX : run + RUN_W'(1);
    assign startEff = (run == '0) ? iH_Cont : runStart;

    // With MARG zero these clamps never bite, since a valid box lies inside the active area.
    assign x1Exp = (minX >= XS + MARG) ? minX - MARG : XS;
    assign x2Exp = (maxX + MARG > XE - 13'd1) ? XE - 13'd1 : maxX + MARG;
    assign y1Exp = (minY >= YS + MARG) ? minY - MARG : YS;
    assign y2Exp = (maxY + MARG > YE - 13'd1) ? YE - 13'd1 : maxY + MARG;

`ifdef BBOX_MARGIN_EN
    assign latchNow = (state == LATCH);
`else
    assign latchNow = (state == ACCUM) && fe;
`endif

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) state <= IDLE;
        else         state <= stateNext;
    end

    always_comb begin
        stateNext = state;
        case (state)
            IDLE:    if (fs) stateNext = ACCUM;
            ACCUM:   if (fe) stateNext = LATCH;
            LATCH:   stateNext = ACCUM;
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            minX <= '1; maxX <= '0; minY <= '1; maxY <= '0;
            runStart <= '0; run <= '0; rowCnt <= '0; rowq <= 1'b0;
        end else if (fs) begin
            minX <= '1; maxX <= '0; minY <= '1; maxY <= '0;
            run <= '0; rowCnt <= '0; rowq <= 1'b0;
        end else if (state == ACCUM) begin
            if (re) begin
                // rowq already reflects the last active pixel, sampled the cycle before
                if (rowq) begin
                    if (iV_Cont < minY) minY <= iV_Cont;
                    if (iV_Cont > maxY) maxY <= iV_Cont;
                    if (rowCnt != ROW_MAX) rowCnt <= rowCnt + ROW_W'(1);
                end
                run  <= '0;
                rowq <= 1'b0;
            end else if (white) begin
                if (run == '0) runStart <= iH_Cont;
                run <= runPost;
                if (runPost == RUN_MAX) begin
                    if (iH_Cont > maxX) maxX <= iH_Cont;
                    if (run != RUN_MAX) begin
                        rowq <= 1'b1;
                        if (startEff < minX) minX <= startEff;
                    end
                end
            end else begin
                run <= '0;
            end
        end
    end

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            oX1 <= '0; oX2 <= '0; oY1 <= '0; oY2 <= '0;
            oValid <= 1'b0; oDone <= 1'b0;
        end else begin
            oDone <= latchNow;
            if (latchNow) begin
                if (rowCnt == ROW_MAX) begin
                    oX1 <= x1Exp; oX2 <= x2Exp; oY1 <= y1Exp; oY2 <= y2Exp;
                    oValid <= 1'b1;
                end else begin
                    oValid <= 1'b0;
                end
            end
        end
    end
endmodule
